// File: rtl/pow_sched.sv
// pow_sched: round-robin shared unit computing x^n mod 2^W for NREQ requesters
// by repeated multiplication, with a registered one-hot grant/done handshake.
module pow_sched #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int NW   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*W-1:0]    x_in,
    input  logic [NREQ*NW-1:0]   n_in,
    output logic [NREQ-1:0]      gnt,
    output logic                 busy,
    output logic [W-1:0]         result,
    output logic [NREQ-1:0]      done
);
    localparam int KW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   last_q, last_d, k_q, k_d, win;
    logic [W-1:0]    acc_q, acc_d, xr_q, xr_d, result_q, result_d, x_sel;
    logic [NW-1:0]   cnt_q, cnt_d, n_sel;
    logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d;
    logic            found;

    // Round robin: the first requester after the last winner, wrapping around.
    always_comb begin
        win = last_q;
        found = 1'b0;
        for (int j = 1; j <= NREQ; j++) begin
            if (!found && req[(int'(last_q) + j) % NREQ]) begin
                win = KW'((int'(last_q) + j) % NREQ);
                found = 1'b1;
            end
        end
    end

    assign x_sel = x_in[int'(win)*W +: W];
    assign n_sel = n_in[int'(win)*NW +: NW];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= KW'(NREQ - 1);
            k_q      <= '0;
            acc_q    <= '0;
            xr_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            xr_q     <= xr_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = (state_q == IDLE) ? (|req ? RUN : IDLE) :
                  (state_q == RUN)  ? ((cnt_q == '0) ? DONE : RUN) : IDLE;
    end

    always_comb begin
        k_d      = k_q;
        last_d   = last_q;
        xr_d     = xr_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        result_d = result_q;
        if (state_q == IDLE && |req) begin
            k_d   = win;
            xr_d  = x_sel;
            acc_d = (n_sel == '0) ? W'(1) : x_sel;
            cnt_d = (n_sel == '0) ? '0 : n_sel - NW'(1);
            gnt_d = NREQ'(1) << win;
        end else if (state_q == RUN) begin
            if (cnt_q != '0) begin
                acc_d = acc_q * xr_q;
                cnt_d = cnt_q - NW'(1);
            end else begin
                done_d   = gnt_q;
                result_d = acc_q;
            end
        end else if (state_q == DONE) begin
            gnt_d  = '0;
            last_d = k_q;
        end
    end

    assign gnt    = gnt_q;
    assign done   = done_q;
    assign result = result_q;
    assign busy   = (state_q != IDLE);
endmodule
